// File: rtl/if_fetch_stage.sv
// if_fetch_stage -- instruction-fetch stage, producer side of fetch->decode.
//
// Keeps the program counter and issues sequential word fetches on a
// valid/ready request channel. Returned instructions are held in a small
// in-order queue and presented to decode as (insn, pc) pairs with valid/ready
// flow control. A redirect from execute flushes the queue, retargets the PC
// and marks every request still in flight as stale so its response is
// discarded when it returns.
//
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   imem_req_*        fetch request channel (valid/ready, word address)
//   imem_resp_*       in-order fetch responses, always accepted
//   redirect_*        control-flow change from execute (target[1:0] ignored)
//   id_valid/id_ready handshake to decode
//   insn, pc          head of the fetch queue (NOP_INSN / 0 when empty)
module if_fetch_stage #(
    parameter int                ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter int                DEPTH    = 2,
    parameter logic [31:0]       NOP_INSN = 32'h0000_0013
) (
    input  logic              clk,
    input  logic              rst,
    output logic              imem_req_valid,
    input  logic              imem_req_ready,
    output logic [ADDR_W-1:0] imem_req_addr,
    input  logic              imem_resp_valid,
    input  logic [31:0]       imem_resp_data,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_target,
    output logic              id_valid,
    input  logic              id_ready,
    output logic [31:0]       insn,
    output logic [ADDR_W-1:0] pc
);

    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [CNT_W:0] W_DEPTH = (CNT_W + 1)'(DEPTH);

    // Holds the request channel idle for the first cycle after reset release.
    logic              r_started;
    logic [ADDR_W-1:0] r_fetch_pc;
    logic [CNT_W-1:0]  r_outstanding;
    logic [CNT_W-1:0]  r_drop_cnt;

    // Addresses of in-flight requests, in issue order; the head pairs with
    // the next response to arrive.
    logic [ADDR_W-1:0] r_pend_pc [DEPTH];
    logic [PTR_W-1:0]  r_pend_wr;
    logic [PTR_W-1:0]  r_pend_rd;

    // Fetch queue towards decode.
    logic [31:0]       r_q_insn [DEPTH];
    logic [ADDR_W-1:0] r_q_pc   [DEPTH];
    logic [PTR_W-1:0]  r_q_wr;
    logic [PTR_W-1:0]  r_q_rd;
    logic [CNT_W-1:0]  r_q_count;

    logic              w_credit;
    logic              w_req_fire;
    logic              w_resp_drop;
    logic              w_push;
    logic              w_pop;
    logic [CNT_W-1:0]  w_out_next;
    logic [CNT_W-1:0]  w_drop_next;
    logic [CNT_W-1:0]  w_count_next;
    logic [1:0]        w_unused_tgt_lsb;

    assign w_unused_tgt_lsb = redirect_target[1:0];

    // A slot is reserved in the queue for every request in flight, so the
    // queue can never overflow whatever the memory latency.
    assign w_credit       = ({1'b0, r_outstanding} + {1'b0, r_q_count}) < W_DEPTH;
    assign imem_req_valid = r_started && w_credit && !redirect_valid;
    assign imem_req_addr  = r_fetch_pc;
    assign w_req_fire     = imem_req_valid && imem_req_ready;

    assign w_resp_drop = imem_resp_valid && (r_drop_cnt != '0);
    assign w_push      = imem_resp_valid && !w_resp_drop && !redirect_valid;
    assign w_pop       = id_valid && id_ready && !redirect_valid;

    always_comb begin
        w_out_next   = r_outstanding + CNT_W'(w_req_fire) - CNT_W'(imem_resp_valid);
        w_count_next = r_q_count + CNT_W'(w_push) - CNT_W'(w_pop);
        w_drop_next  = r_drop_cnt;
        if (redirect_valid) begin
            // Everything still in flight after this cycle belongs to the
            // old path, including requests already marked stale.
            w_drop_next = w_out_next;
        end else if (w_resp_drop) begin
            w_drop_next = r_drop_cnt - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_started     <= 1'b0;
            r_fetch_pc    <= RESET_PC;
            r_outstanding <= '0;
            r_drop_cnt    <= '0;
            r_pend_wr     <= '0;
            r_pend_rd     <= '0;
            r_q_wr        <= '0;
            r_q_rd        <= '0;
            r_q_count     <= '0;
        end else begin
            r_started     <= 1'b1;
            r_outstanding <= w_out_next;
            r_drop_cnt    <= w_drop_next;

            if (redirect_valid) begin
                r_fetch_pc <= {redirect_target[ADDR_W-1:2], 2'b00};
            end else if (w_req_fire) begin
                r_fetch_pc <= r_fetch_pc + ADDR_W'(4);
            end

            // The pending-address list is not flushed on redirect: stale
            // entries drain in order as their responses are dropped.
            if (w_req_fire) begin
                r_pend_wr <= r_pend_wr + PTR_W'(1);
            end
            if (imem_resp_valid) begin
                r_pend_rd <= r_pend_rd + PTR_W'(1);
            end

            if (redirect_valid) begin
                r_q_wr    <= '0;
                r_q_rd    <= '0;
                r_q_count <= '0;
            end else begin
                r_q_count <= w_count_next;
                if (w_push) begin
                    r_q_wr <= r_q_wr + PTR_W'(1);
                end
                if (w_pop) begin
                    r_q_rd <= r_q_rd + PTR_W'(1);
                end
            end
        end
    end

    // Storage needs no reset: entries are only read under the counters.
    always_ff @(posedge clk) begin
        if (w_req_fire) begin
            r_pend_pc[r_pend_wr] <= r_fetch_pc;
        end
        if (w_push) begin
            r_q_insn[r_q_wr] <= imem_resp_data;
            r_q_pc[r_q_wr]   <= r_pend_pc[r_pend_rd];
        end
    end

    assign id_valid = (r_q_count != '0);
    assign insn     = id_valid ? r_q_insn[r_q_rd] : NOP_INSN;
    assign pc       = id_valid ? r_q_pc[r_q_rd] : '0;

    a_resp_has_credit: assert property (@(posedge clk) disable iff (rst)
        imem_resp_valid |-> (r_outstanding != '0));
    a_drop_bounded: assert property (@(posedge clk) disable iff (rst)
        r_drop_cnt <= r_outstanding);

endmodule

// File: tb/tb_if_fetch_stage.sv
module tb_if_fetch_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic        redirect_valid;
    logic [31:0] redirect_target;
    logic        id_valid;
    logic        id_ready;
    logic [31:0] insn;
    logic [31:0] pc;

    // Second instance, only used to observe the PC wrap from the top word.
    logic        d1_req_valid;
    logic        d1_req_ready;
    logic [31:0] d1_req_addr;
    logic        d1_resp_valid;
    logic [31:0] d1_resp_data;
    logic        d1_redirect_valid;
    logic [31:0] d1_redirect_target;
    logic        d1_id_valid;
    logic        d1_id_ready;
    logic [31:0] d1_insn;
    logic [31:0] d1_pc;

    int n_tests = 0;
    int n_fail  = 0;
    int fires   = 0;
    int delivs  = 0;
    int cyc     = 0;
    int mem_lat = 1;

    always #5 clk = ~clk;

    if_fetch_stage #(.ADDR_W(32), .RESET_PC(32'h0000_0000), .DEPTH(2),
                     .NOP_INSN(32'h0000_0013)) dut (
        .clk(clk), .rst(rst),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
        .imem_req_addr(imem_req_addr),
        .imem_resp_valid(imem_resp_valid), .imem_resp_data(imem_resp_data),
        .redirect_valid(redirect_valid), .redirect_target(redirect_target),
        .id_valid(id_valid), .id_ready(id_ready), .insn(insn), .pc(pc)
    );

    if_fetch_stage #(.ADDR_W(32), .RESET_PC(32'hFFFF_FFFC), .DEPTH(2),
                     .NOP_INSN(32'h0000_0013)) dut_wrap (
        .clk(clk), .rst(rst),
        .imem_req_valid(d1_req_valid), .imem_req_ready(d1_req_ready),
        .imem_req_addr(d1_req_addr),
        .imem_resp_valid(d1_resp_valid), .imem_resp_data(d1_resp_data),
        .redirect_valid(d1_redirect_valid), .redirect_target(d1_redirect_target),
        .id_valid(d1_id_valid), .id_ready(d1_id_ready), .insn(d1_insn), .pc(d1_pc)
    );

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {16'hC0DE, a[15:0]};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %08h, expected %08h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic probe();
        @(negedge clk);
        #1;
    endtask

    // Instruction memory: fixed latency of mem_lat cycles, in order.
    typedef struct {
        int          due;
        logic [31:0] addr;
    } mreq_t;
    mreq_t mq[$];

    initial begin
        mreq_t e;
        imem_resp_valid = 1'b0;
        imem_resp_data  = 32'h0;
        forever begin
            @(negedge clk);
            if (rst) begin
                mq.delete();
            end else if (imem_req_valid && imem_req_ready) begin
                e.due  = cyc + mem_lat;
                e.addr = imem_req_addr;
                mq.push_back(e);
            end
            @(posedge clk);
            cyc++;
            #1;
            if (!rst && mq.size() > 0 && mq[0].due <= cyc) begin
                imem_resp_valid = 1'b1;
                imem_resp_data  = mem_word(mq[0].addr);
                void'(mq.pop_front());
            end else begin
                imem_resp_valid = 1'b0;
                imem_resp_data  = 32'h0;
            end
        end
    end

    // Reference behaviour: decode must see a gap-free sequential pc stream
    // starting at the reset PC or the latest redirect target, each paired
    // with that address's memory word; requests likewise walk sequentially.
    initial begin
        logic [31:0] exp_pc;
        logic [31:0] exp_req;
        logic        after_redir;
        logic        prev_stall;
        exp_pc      = 32'h0;
        exp_req     = 32'h0;
        after_redir = 1'b0;
        prev_stall  = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                exp_pc      = 32'h0;
                exp_req     = 32'h0;
                after_redir = 1'b0;
                prev_stall  = 1'b0;
                fires       = 0;
                delivs      = 0;
            end else begin
                if (redirect_valid) check("req_valid_during_redirect", 32'(imem_req_valid), 32'd0);
                if (imem_req_valid) begin
                    check("req_addr", imem_req_addr, exp_req);
                    if (imem_req_ready) begin
                        exp_req = exp_req + 32'd4;
                        fires++;
                    end
                end
                if (after_redir) check("id_valid_after_redirect", 32'(id_valid), 32'd0);
                if (prev_stall)  check("id_valid_held_in_stall", 32'(id_valid), 32'd1);
                if (id_valid) begin
                    check("pc", pc, exp_pc);
                    check("insn", insn, mem_word(exp_pc));
                    if (id_ready && !redirect_valid) begin
                        $display("[TB] deliver pc=%08h insn=%08h", pc, insn);
                        exp_pc = exp_pc + 32'd4;
                        delivs++;
                    end
                end else begin
                    check("insn_empty", insn, 32'h0000_0013);
                    check("pc_empty", pc, 32'h0);
                end
                prev_stall  = id_valid && !id_ready && !redirect_valid;
                after_redir = redirect_valid;
                if (redirect_valid) begin
                    exp_pc  = {redirect_target[31:2], 2'b00};
                    exp_req = {redirect_target[31:2], 2'b00};
                end
            end
        end
    end

    initial begin
        int d0;
        logic found;
        rst                = 1'b1;
        imem_req_ready     = 1'b1;
        id_ready           = 1'b1;
        redirect_valid     = 1'b0;
        redirect_target    = 32'h0;
        d1_req_ready       = 1'b1;
        d1_resp_valid      = 1'b0;
        d1_resp_data       = 32'h0;
        d1_redirect_valid  = 1'b0;
        d1_redirect_target = 32'h0;
        d1_id_ready        = 1'b1;
        #1;
        check("reset_req_valid", 32'(imem_req_valid), 32'd0);
        check("reset_id_valid", 32'(id_valid), 32'd0);
        check("reset_insn", insn, 32'h0000_0013);
        check("reset_pc", pc, 32'h0);
        repeat (3) tick();

        // Sequential fetch with a 1-cycle memory, plus the wrap instance.
        rst = 1'b0;                                   // cycle 0
        probe();
        check("t1_c0_req_valid", 32'(imem_req_valid), 32'd0);
        tick(); probe();                              // cycle 1
        check("t1_c1_req_valid", 32'(imem_req_valid), 32'd1);
        check("t1_c1_req_addr", imem_req_addr, 32'h0);
        check("t5_c1_req_addr", d1_req_addr, 32'hFFFF_FFFC);
        tick(); probe();                              // cycle 2
        check("t1_c2_req_addr", imem_req_addr, 32'h4);
        check("t5_c2_req_valid", 32'(d1_req_valid), 32'd1);
        check("t5_c2_req_addr", d1_req_addr, 32'h0);
        tick(); probe();                              // cycle 3
        check("t1_c3_id_valid", 32'(id_valid), 32'd1);
        check("t1_c3_pc", pc, 32'h0);
        check("t1_c3_insn", insn, 32'hC0DE_0000);
        check("t1_c3_req_valid_no_credit", 32'(imem_req_valid), 32'd0);
        check("t5_c3_req_valid_no_credit", 32'(d1_req_valid), 32'd0);

        // Request-channel backpressure: address must hold until accepted.
        tick(); imem_req_ready = 1'b0;
        repeat (3) tick();
        imem_req_ready = 1'b1;
        repeat (10) tick();

        // Decode stall: credits run out, then back-to-back drain.
        id_ready = 1'b0;
        repeat (10) tick();
        probe();
        check("t2_req_valid_stalled", 32'(imem_req_valid), 32'd0);
        check("t2_id_valid_stalled", 32'(id_valid), 32'd1);
        check("t2_buffered", 32'(fires - delivs), 32'd2);
        d0 = delivs;
        tick(); id_ready = 1'b1;
        probe();
        check("t2_release_1", 32'(delivs), 32'(d0 + 1));
        tick(); probe();
        check("t2_release_2", 32'(delivs), 32'(d0 + 2));

        // Redirect with two requests in flight (3-cycle memory).
        tick(); rst = 1'b1; mem_lat = 3;
        tick(); tick();
        rst = 1'b0;                                   // cycle 0
        tick(); tick(); tick();                       // cycle 3
        redirect_valid  = 1'b1;
        redirect_target = 32'h0000_0103;
        probe();
        check("t3_in_flight", 32'(fires - delivs), 32'd2);
        tick(); redirect_valid = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            probe();
            if (id_valid) found = 1'b1;
            else tick();
        end
        check("t3_id_valid_seen", 32'(found), 32'd1);
        check("t3_first_pc", pc, 32'h0000_0100);
        check("t3_first_insn", insn, 32'hC0DE_0100);

        // Redirect in the same cycle a response arrives.
        found = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(posedge clk); #2;
            if (imem_resp_valid) begin
                found = 1'b1;
                break;
            end
        end
        check("t4_resp_seen", 32'(found), 32'd1);
        redirect_valid  = 1'b1;
        redirect_target = 32'h0000_0200;
        probe();
        check("t4_req_valid", 32'(imem_req_valid), 32'd0);
        tick(); redirect_valid = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            probe();
            if (id_valid) found = 1'b1;
            else tick();
        end
        check("t4_id_valid_seen", 32'(found), 32'd1);
        check("t4_first_pc", pc, 32'h0000_0200);

        // Asynchronous reset mid-stream.
        found = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(posedge clk); #3;
            if (id_valid) begin
                found = 1'b1;
                break;
            end
        end
        check("t6_stream_active", 32'(found), 32'd1);
        rst = 1'b1;
        #1;
        check("t6_req_valid", 32'(imem_req_valid), 32'd0);
        check("t6_id_valid", 32'(id_valid), 32'd0);
        check("t6_insn", insn, 32'h0000_0013);
        check("t6_pc", pc, 32'h0);
        tick(); tick();
        mem_lat = 1;
        rst = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            probe();
            if (id_valid) found = 1'b1;
            else tick();
        end
        check("t6_id_valid_seen", 32'(found), 32'd1);
        check("t6_first_pc", pc, 32'h0);
        check("t6_first_insn", insn, 32'hC0DE_0000);
        repeat (10) tick();
        probe();
        check("t6_liveness", 32'(delivs >= 4), 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
